// File: rtl/csa_wide_add_seq.sv
// Sequential WIDTH-bit adder: one 4-bit carry-select slice is reused per cycle,
// LSB chunk first, with the chunk carry held in a register between passes.

module carry_select_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int LO = W / 2;
  localparam int HI = W - LO;

  logic [LO:0]   c_lo;
  logic [HI:0]   c_hi0;
  logic [HI:0]   c_hi1;
  logic [LO-1:0] s_lo;
  logic [HI-1:0] s_hi0;
  logic [HI-1:0] s_hi1;

  assign c_lo[0]  = cin;
  assign c_hi0[0] = 1'b0;
  assign c_hi1[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < LO; gi++) begin : g_lo
      assign s_lo[gi]   = a[gi] ^ b[gi] ^ c_lo[gi];
      assign c_lo[gi+1] = (a[gi] & b[gi]) | (c_lo[gi] & (a[gi] ^ b[gi]));
    end
    // Upper half is computed for both possible carries; the lower carry picks one.
    for (gi = 0; gi < HI; gi++) begin : g_hi
      assign s_hi0[gi]   = a[LO+gi] ^ b[LO+gi] ^ c_hi0[gi];
      assign c_hi0[gi+1] = (a[LO+gi] & b[LO+gi]) | (c_hi0[gi] & (a[LO+gi] ^ b[LO+gi]));
      assign s_hi1[gi]   = a[LO+gi] ^ b[LO+gi] ^ c_hi1[gi];
      assign c_hi1[gi+1] = (a[LO+gi] & b[LO+gi]) | (c_hi1[gi] & (a[LO+gi] ^ b[LO+gi]));
    end
  endgenerate

  assign sum  = {(c_lo[LO] ? s_hi1 : s_hi0), s_lo};
  assign cout = c_lo[LO] ? c_hi1[HI] : c_hi0[HI];
endmodule

module csa_wide_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int CHUNKS = WIDTH / 4;
  localparam int IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [IDXW-1:0]  idx_reg, idx_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;

  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [3:0] slice_sum;
  logic       slice_cout;

  assign slice_a = a_reg[4*idx_reg +: 4];
  assign slice_b = b_reg[4*idx_reg +: 4];

  carry_select_adder #(.W(4)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    idx_next   = idx_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = in_a;
          b_next     = in_b;
          carry_next = in_cin;
          idx_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        sum_next[4*idx_reg +: 4] = slice_sum;
        carry_next = slice_cout;
        idx_next   = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          // Top slice sum bit is the result MSB, so overflow is known here.
          cout_next  = slice_cout;
          ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                       (slice_sum[3] != a_reg[WIDTH-1]);
          idx_next   = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      idx_reg   <= idx_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
  assign out_ovf   = ovf_reg;
endmodule
